// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with hold limit and a mandatory idle gap
// between grants. Drives a one-hot select bus; all outputs are registered.
module arb_rr4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  // Handshake: a requester holds req[i] high while it wants the resource; the
  // winner keeps req high for the whole grant and ends it by pulsing rel or by
  // dropping its req bit. Non-holder req changes are only seen at arbitration.

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  // First requester at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (found) begin
          state_d  = GRANT;
          gnt_id_d = winner;
          ptr_d    = winner + 2'd1;
          hold_d   = 8'd1;
        end
      end
      GRANT: begin
        // Normal release outranks the hold limit when both hit on one edge.
        if (rel || !req[gnt_id_q]) begin
          state_d = IDLE;
          hold_d  = 8'd0;
        end else if (hold_q == HOLD_LIMIT) begin
          state_d   = IDLE;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_id_q  <= 2'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q == GRANT);
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;

  always_comb begin
    gnt = 4'b0000;
    if (state_q == GRANT) gnt[gnt_id_q] = 1'b1;
  end

endmodule
